f_d_fetch_unit: RTL and testbench
=================================

Name: f_d_fetch_unit

Overview:
Fetch-side block of the P6 five-stage MIPS pipeline. It holds the PC register and next-PC select, and consumes the D-stage branch compare results (Beq/Bne) and the jump targets. It also holds the F/D pipeline register that feeds D_Instr and D_PC to the decoder and the comparator. Branches and jumps resolve in D with one architectural delay slot.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset.
NOP_INSTR, 32'h0000_0000, instruction word injected on flush.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
F_Instr  in  32  instruction word read from IM at F_PC
D_Stall  in  1  hazard-unit stall; holds PC and F/D register
D_Flush  in  1  loads NOP into F/D register (reserved for exceptions)
D_NPC_Op  in  2  0=PC+4, 1=branch, 2=j/jal, 3=jr
D_Br_Type  in  1  0=beq, 1=bne (used when D_NPC_Op=1)
D_CMP_Beq  in  1  equality result from D-stage comparator
D_CMP_Bne  in  1  inequality result from D-stage comparator
D_JR_Rs  in  32  forwarded rs value for jr
F_PC  out  32  current fetch PC (to IM)
D_PC  out  32  PC of the instruction in D
D_Instr  out  32  instruction in D
D_PC8  out  32  D_PC+8, link address for jal
D_BrTaken  out  1  combinational: redirect selected this cycle
F_StallCnt  out  32  stats: stalled cycles (see Optional Feature)
F_TakenCnt  out  32  stats: taken redirects (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, highest priority): F_PC<=PC_RESET, D_PC<=PC_RESET, D_Instr<=NOP_INSTR, counters<=0.
- Offset is sign_ext(D_Instr[15:0])<<2. Imm26 is D_Instr[25:0].
- NPC is combinational:
  - Op0: F_PC+4.
  - Op1: if cond then D_PC+4+offset, else F_PC+4. cond = D_Br_Type ? D_CMP_Bne : D_CMP_Beq.
  - Op2: {D_PC[31:28], Imm26, 2'b00}.
  - Op3: D_JR_Rs, used unaligned with no checks.
- D_BrTaken = (Op1 & cond) | Op2 | Op3.
- All adds are 32-bit modulo; wrap at 0xFFFF_FFFC is silent.
- Each edge when not reset:
  - D_Stall=1: F_PC, D_PC and D_Instr hold. D_Flush is ignored while stalled.
  - Else if D_Flush=1: F_PC<=NPC, D_Instr<=NOP_INSTR, D_PC<=F_PC.
  - Else: F_PC<=NPC, D_Instr<=F_Instr, D_PC<=F_PC.
- Delay slot: the instruction at F_PC during a taken redirect always enters D. The block never auto-squashes it.
- Latency: a redirect decided in D in cycle n is visible on F_PC in cycle n+1.
- A stall cycle with a redirect pending does not update PC. The redirect is re-evaluated each cycle from current D inputs until the stall drops.
- D_PC8 = D_PC+8, combinational.
- Reset asserted mid-stall or mid-redirect overrides everything. The next cycle fetches PC_RESET.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: F_StallCnt increments on every non-reset cycle with D_Stall=1. F_TakenCnt increments on every non-stalled, non-reset cycle with D_BrTaken=1. Both are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built. Core behaviour is identical either way.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - NPC_OP_PC4/BRANCH/J/JR encodings (2-bit).
  - BR_BEQ/BR_BNE.
  - PC_RESET_VAL.
  - NOP constant.
- One natural sub-module: npc_sel (purely combinational next-PC and D_BrTaken logic). PC and F/D registers stay in the top.

Test Plan:
- Reset then 3 free cycles, F_Instr constant → F_PC 0x3000,0x3004,0x3008; D_PC lags by one; D_Instr=F_Instr.
- Taken beq: D_PC=0x3010, D_Instr imm=0xFFFE, Op1, BrType0, Beq=1 → F_PC next = 0x300C; D_BrTaken=1. Same case with Beq=0 → F_PC+4.
- Not-taken bne: Op1, BrType1, Bne=0 → sequential F_PC+4.
- j with D_PC=0x3020, imm26=0x0000C10 → F_PC next = 0x0000_3040.
- jr with D_JR_Rs=0x0000_3100 asserted during a 2-cycle D_Stall → F_PC, D_PC, D_Instr frozen 2 cycles, then F_PC=0x3100. With FETCH_STATS_EN: StallCnt=2, TakenCnt=1.
- D_Flush=1 with D_Stall=0 → D_Instr=0, D_PC=prior F_PC. Both asserted → all hold. Reset mid-stall → F_PC=0x3000, D_Instr=0, counters 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the P6 pipeline fetch side: next-PC select
// encodings, branch type encodings, reset PC and the NOP word.
package cpu_defs_pkg;

  // Next-PC source selected by the D-stage decoder
  localparam logic [1:0] NPC_OP_PC4    = 2'd0;
  localparam logic [1:0] NPC_OP_BRANCH = 2'd1;
  localparam logic [1:0] NPC_OP_J      = 2'd2;
  localparam logic [1:0] NPC_OP_JR     = 2'd3;

  // Conditional branch flavour
  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Branch byte offset: sign-extended 16-bit immediate scaled by 4
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/f_d_fetch_unit_npc_sel.sv
// npc_sel: purely combinational next-PC and redirect-taken logic.
// Branch targets are relative to the instruction in D (delay-slot
// semantics), sequential flow is relative to the fetch PC.
module npc_sel
  import cpu_defs_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm26,
  input  logic [1:0]  npc_op,
  input  logic        br_type,
  input  logic        cmp_beq,
  input  logic        cmp_bne,
  input  logic [31:0] jr_rs,
  output logic [31:0] npc,
  output logic        br_taken
);

  logic        cond;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign cond      = (br_type == BR_BNE) ? cmp_bne : cmp_beq;
  assign seq_pc    = f_pc + 32'd4;
  assign br_target = d_pc + 32'd4 + br_offset(d_imm26[15:0]);
  assign j_target  = {d_pc[31:28], d_imm26, 2'b00};

  // Select next PC and flag a redirect; jr target is taken as-is, unaligned allowed
  always_comb begin
    npc      = seq_pc;
    br_taken = 1'b0;
    case (npc_op)
      NPC_OP_BRANCH: begin
        if (cond) begin
          npc      = br_target;
          br_taken = 1'b1;
        end
      end
      NPC_OP_J: begin
        npc      = j_target;
        br_taken = 1'b1;
      end
      NPC_OP_JR: begin
        npc      = jr_rs;
        br_taken = 1'b1;
      end
      default: begin
        npc      = seq_pc;
        br_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/f_d_fetch_unit.sv
// f_d_fetch_unit: PC register, next-PC select and F/D pipeline register.
// Redirects resolve in D with one delay slot: the instruction fetched
// while a redirect is decided always enters D.
// Optional macro FETCH_STATS_EN builds stall / taken-redirect counters;
// without it F_StallCnt and F_TakenCnt are tied to zero.
module f_d_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_VAL,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_Instr,
  input  logic        D_Stall,
  input  logic        D_Flush,
  input  logic [1:0]  D_NPC_Op,
  input  logic        D_Br_Type,
  input  logic        D_CMP_Beq,
  input  logic        D_CMP_Bne,
  input  logic [31:0] D_JR_Rs,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC8,
  output logic        D_BrTaken,
  output logic [31:0] F_StallCnt,
  output logic [31:0] F_TakenCnt
);

  logic [31:0] f_pc_reg;
  logic [31:0] d_pc_reg;
  logic [31:0] d_instr_reg;
  logic [31:0] npc;
  logic        br_taken;

  npc_sel u_npc_sel (
    .f_pc     (f_pc_reg),
    .d_pc     (d_pc_reg),
    .d_imm26  (d_instr_reg[25:0]),
    .npc_op   (D_NPC_Op),
    .br_type  (D_Br_Type),
    .cmp_beq  (D_CMP_Beq),
    .cmp_bne  (D_CMP_Bne),
    .jr_rs    (D_JR_Rs),
    .npc      (npc),
    .br_taken (br_taken)
  );

  // PC and F/D register: stall holds everything, flush injects a NOP into D
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_reg    <= PC_RESET;
      d_pc_reg    <= PC_RESET;
      d_instr_reg <= NOP_INSTR;
    end else if (!D_Stall) begin
      f_pc_reg    <= npc;
      d_pc_reg    <= f_pc_reg;
      d_instr_reg <= D_Flush ? NOP_INSTR : F_Instr;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] taken_cnt_reg;

  // Statistics: stalled cycles and redirects that actually took effect
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
      taken_cnt_reg <= 32'd0;
    end else begin
      if (D_Stall) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end else if (br_taken) begin
        taken_cnt_reg <= taken_cnt_reg + 32'd1;
      end
    end
  end

  assign F_StallCnt = stall_cnt_reg;
  assign F_TakenCnt = taken_cnt_reg;
`else
  assign F_StallCnt = 32'd0;
  assign F_TakenCnt = 32'd0;
`endif

  assign F_PC      = f_pc_reg;
  assign D_PC      = d_pc_reg;
  assign D_Instr   = d_instr_reg;
  assign D_PC8     = d_pc_reg + 32'd8;
  assign D_BrTaken = br_taken;

endmodule

// File: tb/tb_f_d_fetch_unit.sv
// Directed testbench for f_d_fetch_unit: sequential fetch, beq/bne,
// j, jr under stall, PC wrap, flush, stall+flush and reset mid-stall.
// Counter expectations follow FETCH_STATS_EN when it is defined.
module tb_f_d_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_Instr;
  logic        D_Stall;
  logic        D_Flush;
  logic [1:0]  D_NPC_Op;
  logic        D_Br_Type;
  logic        D_CMP_Beq;
  logic        D_CMP_Bne;
  logic [31:0] D_JR_Rs;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [31:0] D_PC8;
  logic        D_BrTaken;
  logic [31:0] F_StallCnt;
  logic [31:0] F_TakenCnt;

  int checks = 0;
  int errors = 0;

  f_d_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .F_Instr    (F_Instr),
    .D_Stall    (D_Stall),
    .D_Flush    (D_Flush),
    .D_NPC_Op   (D_NPC_Op),
    .D_Br_Type  (D_Br_Type),
    .D_CMP_Beq  (D_CMP_Beq),
    .D_CMP_Bne  (D_CMP_Bne),
    .D_JR_Rs    (D_JR_Rs),
    .F_PC       (F_PC),
    .D_PC       (D_PC),
    .D_Instr    (D_Instr),
    .D_PC8      (D_PC8),
    .D_BrTaken  (D_BrTaken),
    .F_StallCnt (F_StallCnt),
    .F_TakenCnt (F_TakenCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pipe(input string tag, input logic [31:0] fpc,
                            input logic [31:0] dpc, input logic [31:0] dinstr);
    check({tag, ".F_PC"}, F_PC, fpc);
    check({tag, ".D_PC"}, D_PC, dpc);
    check({tag, ".D_Instr"}, D_Instr, dinstr);
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] stalls, input logic [31:0] takens);
`ifdef FETCH_STATS_EN
    check({tag, ".stall"}, F_StallCnt, stalls);
    check({tag, ".taken"}, F_TakenCnt, takens);
`else
    check({tag, ".stall"}, F_StallCnt, 32'd0);
    check({tag, ".taken"}, F_TakenCnt, 32'd0);
    if (stalls == takens) begin end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    F_Instr   = 32'h1234_5678;
    D_Stall   = 1'b0;
    D_Flush   = 1'b0;
    D_NPC_Op  = 2'd0;
    D_Br_Type = 1'b0;
    D_CMP_Beq = 1'b0;
    D_CMP_Bne = 1'b0;
    D_JR_Rs   = 32'h0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check_pipe("reset", 32'h3000, 32'h3000, 32'h0);
    check("reset.PC8", D_PC8, 32'h3008);
    check_cnt("reset", 0, 0);

    // Free-running sequential fetch
    step(); check_pipe("seq1", 32'h3004, 32'h3000, 32'h1234_5678);
    step(); check_pipe("seq2", 32'h3008, 32'h3004, 32'h1234_5678);
    step(); check_pipe("seq3", 32'h300C, 32'h3008, 32'h1234_5678);
    step();
    // beq with imm 0xFFFE enters D at 0x3010
    F_Instr = 32'h1000_FFFE;
    step(); check_pipe("br_in_d", 32'h3014, 32'h3010, 32'h1000_FFFE);
    check("br.PC8", D_PC8, 32'h3018);

    D_NPC_Op = 2'd1; D_Br_Type = 1'b0; D_CMP_Beq = 1'b0; D_CMP_Bne = 1'b1;
    #1 check("beq_nt.taken", {31'd0, D_BrTaken}, 32'd0);
    D_CMP_Beq = 1'b1; D_CMP_Bne = 1'b0;
    #1 check("beq_t.taken", {31'd0, D_BrTaken}, 32'd1);
    F_Instr = 32'h0000_0001;   // delay slot instruction, imm = 1
    step(); check_pipe("beq_t", 32'h300C, 32'h3014, 32'h0000_0001);
    check_cnt("beq_t", 0, 1);

    // bne not taken (Beq=1 must be ignored for bne) -> sequential
    D_Br_Type = 1'b1; D_CMP_Beq = 1'b1; D_CMP_Bne = 1'b0;
    #1 check("bne_nt.taken", {31'd0, D_BrTaken}, 32'd0);
    step(); check("bne_nt.F_PC", F_PC, 32'h3010);
    // bne not taken on the new D instr, then beq with Beq=0 -> sequential
    D_Br_Type = 1'b0; D_CMP_Beq = 1'b0; D_CMP_Bne = 1'b1;
    step(); check("beq_nt.F_PC", F_PC, 32'h3014);

    // Walk forward to D_PC = 0x3020 with a j instruction
    D_NPC_Op = 2'd0;
    step(); step();
    check_pipe("walk", 32'h301C, 32'h3018, 32'h0000_0001);
    step();
    F_Instr = 32'h0800_0C10;
    step(); check_pipe("j_in_d", 32'h3024, 32'h3020, 32'h0800_0C10);
    D_NPC_Op = 2'd2;
    #1 check("j.taken", {31'd0, D_BrTaken}, 32'd1);
    F_Instr = 32'hAAAA_0000;
    step(); check_pipe("j", 32'h3040, 32'h3024, 32'hAAAA_0000);
    check_cnt("j", 0, 2);

    // jr held by a two-cycle stall
    D_NPC_Op = 2'd3; D_JR_Rs = 32'h0000_3100; D_Stall = 1'b1;
    F_Instr = 32'hBBBB_0000;
    #1 check("jr.taken", {31'd0, D_BrTaken}, 32'd1);
    step(); check_pipe("jr_st1", 32'h3040, 32'h3024, 32'hAAAA_0000);
    step(); check_pipe("jr_st2", 32'h3040, 32'h3024, 32'hAAAA_0000);
    check_cnt("jr_st2", 2, 2);
    D_Stall = 1'b0;
    step(); check_pipe("jr", 32'h3100, 32'h3040, 32'hBBBB_0000);
    check_cnt("jr", 2, 3);

    // Silent wrap at 0xFFFF_FFFC
    D_JR_Rs = 32'hFFFF_FFFC;
    step(); check("wrap.jr", F_PC, 32'hFFFF_FFFC);
    D_NPC_Op = 2'd0;
    step(); check("wrap.F_PC", F_PC, 32'h0000_0000);
    check("wrap.PC8", D_PC8, 32'h0000_0004);

    // Unaligned jr target passes straight through
    D_NPC_Op = 2'd3; D_JR_Rs = 32'h0000_3101;
    step(); check_pipe("jr_unal", 32'h3101, 32'h0000_0000, 32'hBBBB_0000);
    check_cnt("jr_unal", 2, 5);

    // Flush without stall
    D_NPC_Op = 2'd0; F_Instr = 32'hCCCC_0000; D_Flush = 1'b1;
    step(); check_pipe("flush", 32'h3105, 32'h3101, 32'h0);
    // Flush while stalled: everything holds
    D_Stall = 1'b1; F_Instr = 32'hDDDD_0000;
    step(); check_pipe("st_flush", 32'h3105, 32'h3101, 32'h0);
    check_cnt("st_flush", 3, 5);

    // Reset mid-stall with a jr pending
    D_Flush = 1'b0; D_NPC_Op = 2'd3; D_JR_Rs = 32'h0000_5000; reset = 1'b1;
    step(); check_pipe("rst_mid", 32'h3000, 32'h3000, 32'h0);
    check_cnt("rst_mid", 0, 0);
    reset = 1'b0; D_Stall = 1'b0; D_NPC_Op = 2'd0;
    step(); check_pipe("post_rst", 32'h3004, 32'h3000, 32'hDDDD_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
